// File: rtl/addsub_pkg.sv
// Shared types and constants for the 4-bit add/subtract accumulator.
package addsub_pkg;

   localparam int DW = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/adder_4bit.sv
// Plain ripple-style adder with carry in and carry out.
module adder_4bit
   import addsub_pkg::*;
(
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic          cin,
   output logic [DW-1:0] sum,
   output logic          cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};

endmodule

// File: rtl/addsub_acc_4bit.sv
// Accumulator that adds or subtracts a 4-bit operand per handshake, reporting
// carry, signed overflow and zero, plus a count of accepted requests.
module addsub_acc_4bit
   import addsub_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_op,
   input  logic             in_clr,
   input  logic [DW-1:0]    in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    out_acc,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero,
   output logic [CNT_W-1:0] out_count
);

   state_t        state;
   logic          op_q;
   logic          clr_q;
   logic [DW-1:0] b_q;
   logic [DW-1:0] acc;
   logic [DW-1:0] a_op;
   logic [DW-1:0] b_eff;
   logic [DW-1:0] sum;
   logic          cout;
   logic          ovf;

   // Subtraction is a + ~b + 1, so the op bit doubles as the carry in.
   assign a_op  = clr_q ? '0 : acc;
   assign b_eff = (op_q == OP_SUB) ? ~b_q : b_q;
   assign ovf   = (a_op[DW-1] == b_eff[DW-1]) && (sum[DW-1] != a_op[DW-1]);

   adder_4bit u_adder (
      .a    (a_op),
      .b    (b_eff),
      .cin  (op_q == OP_SUB),
      .sum  (sum),
      .cout (cout)
   );

   // NOTE: all state updates use <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         op_q      <= OP_ADD;
         clr_q     <= 1'b0;
         b_q       <= '0;
         acc       <= '0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
         out_count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_q      <= in_op;
                  clr_q     <= in_clr;
                  b_q       <= in_b;
                  out_count <= out_count + CNT_W'(1);
                  state     <= ST_CALC;
               end
            end
            ST_CALC: begin
               acc      <= sum;
               out_cout <= cout;
               out_ovf  <= ovf;
               state    <= ST_HOLD;
            end
            ST_HOLD: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_HOLD);
   assign out_acc   = acc;
   assign out_zero  = (acc == '0);

endmodule

// File: tb/tb_addsub_acc_4bit.sv
// Scoreboard bench: the driver queues expected results, a monitor checks each
// result as it is handed off downstream.
module tb_addsub_acc_4bit;

   localparam int CNT_W = 8;

   typedef struct {
      logic [3:0]       acc;
      logic             cout;
      logic             ovf;
      logic             zero;
      logic [CNT_W-1:0] count;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             in_op = 1'b0;
   logic             in_clr = 1'b0;
   logic [3:0]       in_b = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [3:0]       out_acc;
   logic             out_cout;
   logic             out_ovf;
   logic             out_zero;
   logic [CNT_W-1:0] out_count;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   addsub_acc_4bit #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_clr    (in_clr),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_acc   (out_acc),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .out_zero  (out_zero),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Inputs change just after the rising edge; outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      if (!in_ready) check("in_ready timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic issue(input logic op, input logic clr, input logic [3:0] b,
                        input logic [3:0] eacc, input logic ecout, input logic eovf,
                        input logic ezero, input logic [CNT_W-1:0] ecount);
      exp_t e;
      e.acc = eacc; e.cout = ecout; e.ovf = eovf; e.zero = ezero; e.count = ecount;
      wait_ready();
      sb.push_back(e);
      in_valid = 1'b1; in_op = op; in_clr = clr; in_b = b;
      step();
      in_valid = 1'b0;
   endtask

   // Monitor: each downstream handoff pops and compares one expected result.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected result", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("out_acc",   32'(out_acc),   32'(e.acc));
               check("out_cout",  32'(out_cout),  32'(e.cout));
               check("out_ovf",   32'(out_ovf),   32'(e.ovf));
               check("out_zero",  32'(out_zero),  32'(e.zero));
               check("out_count", 32'(out_count), 32'(e.count));
            end
         end
      end
   end

   initial begin
      int n;
      logic [CNT_W-1:0] cnt;

      // Reset state
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rst in_ready",  32'(in_ready),  32'd1);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst out_acc",   32'(out_acc),   32'd0);
      check("rst out_zero",  32'(out_zero),  32'd1);
      check("rst out_count", 32'(out_count), 32'd0);
      step();

      //     op clr b      acc   cout  ovf   zero  count
      issue(1'b0, 1'b1, 4'h5, 4'h5, 1'b0, 1'b0, 1'b0, 8'd1);
      issue(1'b0, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 8'd2);
      issue(1'b0, 1'b0, 4'hF, 4'hE, 1'b1, 1'b0, 1'b0, 8'd3);
      issue(1'b0, 1'b1, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0, 8'd4);
      issue(1'b1, 1'b0, 4'h3, 4'h0, 1'b1, 1'b0, 1'b1, 8'd5);
      issue(1'b1, 1'b0, 4'h1, 4'hF, 1'b0, 1'b0, 1'b0, 8'd6);
      issue(1'b0, 1'b1, 4'h7, 4'h7, 1'b0, 1'b0, 1'b0, 8'd7);
      issue(1'b0, 1'b0, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0, 8'd8);
      issue(1'b1, 1'b0, 4'h1, 4'h7, 1'b1, 1'b1, 1'b0, 8'd9);

      // Backpressure: result held while in_valid keeps pushing new operands
      wait_ready();
      out_ready = 1'b0;
      issue(1'b0, 1'b1, 4'h2, 4'h2, 1'b0, 1'b0, 1'b0, 8'd10);
      in_valid = 1'b1; in_clr = 1'b0; in_b = 4'h9;
      step();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp out_valid", 32'(out_valid), 32'd1);
         check("bp in_ready",  32'(in_ready),  32'd0);
         check("bp out_acc",   32'(out_acc),   32'h2);
         check("bp out_count", 32'(out_count), 32'd10);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;

      // Reset while the accepted operation is in CALC discards it
      wait_ready();
      in_valid = 1'b1; in_op = 1'b0; in_clr = 1'b1; in_b = 4'h4;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("calc out_count", 32'(out_count), 32'd11);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("midrst in_ready",  32'(in_ready),  32'd1);
      check("midrst out_valid", 32'(out_valid), 32'd0);
      check("midrst out_acc",   32'(out_acc),   32'd0);
      check("midrst out_zero",  32'(out_zero),  32'd1);
      check("midrst out_count", 32'(out_count), 32'd0);
      step();
      @(negedge clk);
      check("midrst no result", 32'(out_valid), 32'd0);
      step();

      // 256 accepts wrap the counter back to zero
      cnt = '0;
      for (int i = 0; i < 256; i++) begin
         cnt = cnt + 8'd1;
         issue(1'b0, 1'b1, 4'(i), 4'(i), 1'b0, 1'b0, (4'(i) == 4'h0), cnt);
      end

      n = 0;
      while ((sb.size() != 0 || !in_ready) && n < 50) begin
         step();
         n++;
      end
      check("scoreboard drained", 32'(sb.size()), 32'd0);
      @(negedge clk);
      check("wrap out_count", 32'(out_count), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/addsub_acc_4bit.md
ADDSUB_ACC_4BIT -- requirements
Module: addsub_acc_4bit

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, setting the width of the accepted-operation counter.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: in_valid  input  1  operand request present.
REQ-006 Port: in_ready  output  1  block can accept a request.
REQ-007 Port: in_op  input  1  0 = add, 1 = subtract.
REQ-008 Port: in_clr  input  1  1 = use 0 instead of the accumulator as operand A.
REQ-009 Port: in_b  input  4  operand B.
REQ-010 Port: out_valid  output  1  result held and valid.
REQ-011 Port: out_ready  input  1  downstream takes the result.
REQ-012 Port: out_acc  output  4  accumulator value.
REQ-013 Port: out_cout  output  1  adder carry-out; for subtract, 1 = no borrow.
REQ-014 Port: out_ovf  output  1  signed (two's-complement) overflow of the last operation.
REQ-015 Port: out_zero  output  1  out_acc == 0.
REQ-016 Port: out_count  output  CNT_W  number of accepted requests since reset.

Function
REQ-017 The FSM SHALL have 3 states: IDLE, CALC and HOLD.
REQ-018 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in HOLD.
REQ-019 In IDLE, in_valid=1 at a rising edge SHALL capture in_op, in_clr and in_b, increment out_count, and move the FSM to CALC.
REQ-020 In CALC, A = (clr ? 0 : acc), B_eff = (op ? ~b : b) and cin = op.
REQ-021 The rising edge that leaves CALC SHALL load acc from the adder sum, load out_cout and out_ovf, and move the FSM to HOLD.
REQ-022 out_ovf SHALL be (A[3]==B_eff[3]) && (sum[3]!=A[3]).
REQ-023 Latency SHALL be: accepted at edge k, out_valid=1 from edge k+1.
REQ-024 In HOLD, the FSM SHALL stay in HOLD while out_ready=0, with all outputs stable.
REQ-025 In HOLD, out_ready=1 at an edge SHALL return the FSM to IDLE.
REQ-026 There SHALL be no same-cycle pass-through from output to input.
REQ-027 During backpressure, in_ready SHALL be 0, and in_valid SHALL be ignored outside IDLE.
REQ-028 The sum SHALL wrap modulo 16, with the carry reported only on out_cout.
REQ-029 out_count SHALL wrap from 2^CNT_W-1 to 0 without any flag.
REQ-030 out_acc, out_cout, out_ovf and out_zero SHALL keep their last values in IDLE and CALC.
REQ-031 out_zero SHALL be combinational from acc.

Reset
REQ-032 When rst=1 at an edge, the block SHALL set: FSM=IDLE, acc=0, out_cout=0, out_ovf=0, out_count=0 and captured operands=0.
REQ-033 After reset, the outputs SHALL be: in_ready=1, out_valid=0, out_zero=1.
REQ-034 Reset SHALL take priority over any handshake in the same cycle.
REQ-035 Reset in CALC or HOLD SHALL discard the in-flight result.

Structure
REQ-036 Package addsub_pkg SHALL hold the FSM state encoding, the op codes OP_ADD=0 and OP_SUB=1, and the data width constant DW=4.
REQ-037 The arithmetic SHALL be one instance of the team's existing adder_4bit (a, b, cin, sum, cout), with no other sub-modules.

Verification
REQ-038 Scenario (reset): assert rst -> in_ready=1, out_valid=0, out_acc=0, out_zero=1, out_count=0.
REQ-039 Scenario (clear-add, wrap): clr add b=5 -> out_acc=5, cout=0, ovf=0; then add b=F to acc F (after clr add F) -> acc=E, cout=1, ovf=0.
REQ-040 Scenario (subtract): acc=3, sub b=3 -> acc=0, zero=1, cout=1, ovf=0; then sub b=1 -> acc=F, cout=0.
REQ-041 Scenario (signed overflow): acc=7, add b=1 -> acc=8, ovf=1; acc=8, sub b=1 -> acc=7, ovf=1.
REQ-042 Scenario (backpressure): hold out_ready=0 for 3 cycles in HOLD with in_valid=1 -> out_valid stays 1, in_ready=0, acc stable, out_count unchanged until release.
REQ-043 Scenario (reset mid-operation): assert rst in CALC after accept -> next cycle IDLE, acc=0, out_count=0; and 256 accepts with CNT_W=8 -> out_count=0.
